regfile_dump: RTL and testbench

//   Register file directly upstream of the ALU: two combinational read ports

---
 rtl/regfile_dump_if.sv | 34 +++
 rtl/regfile_dump.sv | 102 ++++++++++
 tb/tb_regfile_dump.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_if.sv
// Register-file / dump bus bundle.
// master = driver of addresses, write data and dump controls (ALU side, testbench).
// slave  = the register file itself.
interface regfile_dump_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]    ra1;
  logic [AW-1:0]    ra2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             we3;
  logic [AW-1:0]    wa3;
  logic [WIDTH-1:0] wd3;
  logic             dump_start;
  logic             dump_ready;
  logic             dump_valid;
  logic [AW-1:0]    dump_idx;
  logic [WIDTH-1:0] dump_data;
  logic             dump_busy;
  logic             dump_done;

  modport master (
    output ra1, ra2, we3, wa3, wd3, dump_start, dump_ready,
    input  rd1, rd2, dump_valid, dump_idx, dump_data, dump_busy, dump_done
  );

  modport slave (
    input  ra1, ra2, we3, wa3, wd3, dump_start, dump_ready,
    output rd1, rd2, dump_valid, dump_idx, dump_data, dump_busy, dump_done
  );
endinterface

// File: rtl/regfile_dump.sv
// regfile_dump: 2R/1W register file with r0 hardwired to zero, plus a
// valid/ready engine that streams every register out for debug.
// Optional feature macro: REGFILE_BYPASS_EN -- write-through forwarding of
// wd3 onto the read ports in the write cycle. dump_data is never forwarded.
module regfile_dump #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  regfile_dump_if.slave  rf_bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic {IDLE, DUMP} state_e;

  logic [NREGS-1:0][WIDTH-1:0] rf_q;
  state_e                      state_q;
  logic [AW-1:0]               idx_q;
  logic                        valid_q;
  logic                        busy_q;
  logic                        done_q;
  logic [WIDTH-1:0]            rd1_d;
  logic [WIDTH-1:0]            rd2_d;
  logic                        wr_en;
  logic                        hs;

  // r0 is never a write target, so its storage stays at its reset value
  assign wr_en = rf_bus.we3 && (rf_bus.wa3 != '0);
  assign hs    = valid_q && rf_bus.dump_ready;

  // Write port: one register per edge, r0 discarded; reset clears all
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_q <= '0;
    end else if (wr_en) begin
      rf_q[rf_bus.wa3] <= rf_bus.wd3;
    end
  end

  // Read ports: zero-latency, r0 forced to zero, optional same-cycle forwarding
  always_comb begin
    rd1_d = (rf_bus.ra1 == '0) ? '0 : rf_q[rf_bus.ra1];
    rd2_d = (rf_bus.ra2 == '0) ? '0 : rf_q[rf_bus.ra2];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (rf_bus.wa3 == rf_bus.ra1)) rd1_d = rf_bus.wd3;
    if (wr_en && (rf_bus.wa3 == rf_bus.ra2)) rd2_d = rf_bus.wd3;
`endif
  end

  assign rf_bus.rd1 = rd1_d;
  assign rf_bus.rd2 = rd2_d;

  // Dump FSM: start only honoured in IDLE; one beat per handshake; done pulses
  // for the single cycle following acceptance of the final beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rf_bus.dump_start) begin
            state_q <= DUMP;
            idx_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        DUMP: begin
          if (hs) begin
            if (idx_q == LAST_IDX) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Beat data tracks the stored value live so a stalled beat reflects writes
  assign rf_bus.dump_data  = (idx_q == '0) ? '0 : rf_q[idx_q];
  assign rf_bus.dump_valid = valid_q;
  assign rf_bus.dump_idx   = idx_q;
  assign rf_bus.dump_busy  = busy_q;
  assign rf_bus.dump_done  = done_q;
endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: reset, read/write, r0, forwarding,
// streaming dump with and without backpressure, restart-ignore, mid-dump reset.
module tb_regfile_dump;
  localparam int WIDTH = 32;
  localparam int NREGS = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;
  logic [31:0] mdl [NREGS];

  always #5 clk = ~clk;

  regfile_dump_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus ();

  regfile_dump #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rf_bus  (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int e;
    bus.ra1 = '0; bus.ra2 = '0; bus.we3 = 1'b0; bus.wa3 = '0; bus.wd3 = '0;
    bus.dump_start = 1'b0; bus.dump_ready = 1'b0;
    for (int k = 0; k < NREGS; k++) mdl[k] = 32'd0;

    // reset state
    repeat (2) @(negedge clk);
    bus.ra1 = 5'd5;
    #1;
    chk("rst_valid", 32'(bus.dump_valid), 32'd0);
    chk("rst_busy",  32'(bus.dump_busy),  32'd0);
    chk("rst_done",  32'(bus.dump_done),  32'd0);
    chk("rst_idx",   32'(bus.dump_idx),   32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: reads after reset
    @(negedge clk);
    bus.ra1 = 5'd5; bus.ra2 = 5'd0;
    #1;
    chk("t1_rd1", bus.rd1, 32'd0);
    chk("t1_rd2", bus.rd2, 32'd0);

    // 2: write r8, attempt r0
    @(negedge clk);
    bus.we3 = 1'b1; bus.wa3 = 5'd8; bus.wd3 = 32'hDEADBEEF;
    @(negedge clk);
    bus.wa3 = 5'd0; bus.wd3 = 32'h1234;
    @(negedge clk);
    bus.we3 = 1'b0; bus.ra1 = 5'd8; bus.ra2 = 5'd0;
    #1;
    chk("t2_rd1", bus.rd1, 32'hDEADBEEF);
    chk("t2_rd2", bus.rd2, 32'd0);

    // 3: async reset clears, then same-cycle read of a write
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t3_rst_clear", bus.rd1, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    bus.we3 = 1'b1; bus.wa3 = 5'd9; bus.wd3 = 32'hA5A5A5A5; bus.ra1 = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("t3_pre_edge", bus.rd1, 32'hA5A5A5A5);
`else
    chk("t3_pre_edge", bus.rd1, 32'd0);
`endif
    @(negedge clk);
    bus.we3 = 1'b0;
    #1;
    chk("t3_post_edge", bus.rd1, 32'hA5A5A5A5);

    // 4a: load rf[k]=3k, dump with ready held high
    for (int k = 1; k < NREGS; k++) begin
      @(negedge clk);
      bus.we3 = 1'b1; bus.wa3 = 5'(k); bus.wd3 = 32'(k * 3);
      mdl[k] = 32'(k * 3);
    end
    @(negedge clk);
    bus.we3 = 1'b0; bus.ra1 = 5'd31;
    #1;
    chk("t4_rd31", bus.rd1, 32'd93);
    bus.dump_ready = 1'b1; bus.dump_start = 1'b1;
    @(negedge clk);
    bus.dump_start = 1'b0;
    for (int k = 0; k < NREGS; k++) begin
      chk("t4_valid", 32'(bus.dump_valid), 32'd1);
      chk("t4_busy",  32'(bus.dump_busy),  32'd1);
      chk("t4_idx",   32'(bus.dump_idx),   32'(k));
      chk("t4_data",  bus.dump_data,       mdl[k]);
      @(negedge clk);
    end
    chk("t4_done_hi", 32'(bus.dump_done),  32'd1);
    chk("t4_valid_lo", 32'(bus.dump_valid), 32'd0);
    @(negedge clk);
    chk("t4_done_lo", 32'(bus.dump_done),  32'd0);

    // 4b: ready toggling; a write to r5 while its beat is stalled shows up
    bus.dump_ready = 1'b0; bus.dump_start = 1'b1;
    @(negedge clk);
    bus.dump_start = 1'b0;
    e = 0;
    for (int c = 0; c < 200 && e < NREGS; c++) begin
      bus.dump_ready = (c % 2 == 0);
      bus.we3 = 1'b0;
      if (e == 5 && !bus.dump_ready) begin
        bus.we3 = 1'b1; bus.wa3 = 5'd5; bus.wd3 = 32'h55AA;
      end
      #1;
      chk("t4s_idx",  32'(bus.dump_idx), 32'(e));
      chk("t4s_data", bus.dump_data,     mdl[e]);
      @(negedge clk);
      if (bus.we3) mdl[5] = 32'h55AA;
      if (bus.dump_ready) e++;
    end
    bus.we3 = 1'b0;
    chk("t4s_beats", 32'(e), 32'(NREGS));
    chk("t4s_done",  32'(bus.dump_done), 32'd1);
    @(negedge clk);

    // 5: start ignored mid-dump, reset mid-dump
    bus.dump_ready = 1'b1; bus.dump_start = 1'b1;
    @(negedge clk);
    bus.dump_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_idx4", 32'(bus.dump_idx), 32'd4);
    bus.dump_ready = 1'b0; bus.dump_start = 1'b1;
    @(negedge clk);
    bus.dump_start = 1'b0;
    chk("t5_norestart_idx", 32'(bus.dump_idx), 32'd4);
    chk("t5_norestart_busy", 32'(bus.dump_busy), 32'd1);
    bus.dump_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("t5_idx12", 32'(bus.dump_idx), 32'd12);
    bus.ra1 = 5'd9;
    #1;
    chk("t5_rd1_pre", bus.rd1, 32'd27);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(bus.dump_valid), 32'd0);
    chk("t5_rst_busy",  32'(bus.dump_busy),  32'd0);
    chk("t5_rst_rd1",   bus.rd1,             32'd0);
    chk("t5_rst_done",  32'(bus.dump_done),  32'd0);
    @(negedge clk);
    chk("t5_rst_done2", 32'(bus.dump_done),  32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t5_idle_done", 32'(bus.dump_done),  32'd0);
    chk("t5_idle_valid", 32'(bus.dump_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
